counter6_step: RTL and testbench
================================

# counter6_step

Six-bit programmable counter that advances once per rising edge of the divided tick from the upstream divide-by-7 stage. Operates entirely in the `clock` domain and edge-detects `tick` rather than using it as a clock. Drives the 6-bit value probed on the scope together with a terminal-count pulse and a direction flag. Supports up-wrap, down-wrap, ping-pong and hold modes, a programmable limit, and synchronous load.

## Interface
- `WIDTH`, 6, counter width; `count`, `limit` and `load_val` are `WIDTH` bits.
- `clock`  in  1  system clock; `tick` is generated from it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  divided clock from the divide-by-7 stage, synchronous to `clock`.
- `en`  in  1  step enable; when low, `tick` edges are dropped.
- `mode`  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold.
- `limit`  in  WIDTH  inclusive upper bound of the count range.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value loaded on `load`.
- `count`  out  WIDTH  current count.
- `dir`  out  1  0 = counting up, 1 = counting down.
- `tc`  out  1  one-clock pulse on wrap or turn-around.
- `step`  out  1  one-clock pulse for each accepted tick edge.

## Operation
- `tick_q` registers `tick` every clock.
- `rise = tick & ~tick_q`.
- Accepted step: `rise & en & ~load & (mode != 11)`.
- `load` has priority over everything:
  - `count` ← `load_val`.
  - `dir` is unchanged.
  - `tc` = 0.
  - A coincident rise is discarded.
- Up-wrap (00):
  - `count < limit`: `count + 1`.
  - Otherwise (including `count > limit`): `count` ← 0, `tc` = 1.
  - `dir` forced to 0 at the first step.
- Down-wrap (01):
  - `count == 0`: `count` ← `limit`, `tc` = 1.
  - `count > limit`: `count` ← `limit`, no `tc`.
  - Otherwise: `count − 1`.
  - `dir` forced to 1 at the first step.
- Ping-pong (10), two-state FSM `UP`/`DOWN`, reflected on `dir`:
  - `UP`: `count < limit` → `+1`. Otherwise → `count` ← `limit − 1`, go to `DOWN`, `tc` = 1.
  - `DOWN`: `count > 0` and `≤ limit` → `−1`. At 0 → `count` ← 1, go to `UP`, `tc` = 1. Above `limit` → `count` ← `limit`, no `tc`.
- `limit` = 0, all modes except hold: `count` stays 0 and `tc` pulses on every step.
- Ping-pong with `limit` = 1: sequence 0,1,0,1…, with `tc` on every step.
- Hold (11): `count` and `dir` are frozen and `tc` = 0; `tick_q` keeps tracking.
- Changing `mode` or `limit` mid-count takes effect at the next step. No reset of `count` occurs.
- Arithmetic is unsigned `WIDTH`-bit and never relies on natural overflow; wraps are explicit.

## Timing
- Reset values: `count` = 0, `dir` = 0, `tc` = 0, `step` = 0, `tick_q` = 0.
- If `tick` is 1 on the first clock after reset release, that counts as a rise.
- Latency:
  - `tick` goes high after clock edge N.
  - `rise` is true during cycle N→N+1.
  - `count`, `tc` and `step` update at edge N+1.
- `tc` and `step` are registered, high for exactly one clock, and aligned with the `count` update.
- With the upstream period of 7 clocks, steps arrive every 7 clocks. Back-to-back steps are legal at every second clock (minimum `tick` period 2).
- A `tick` held high produces exactly one step.
- Reset asserted mid-count returns all outputs to reset values asynchronously. No partial step completes.

## Structure
- Shared package `counter6_pkg`:
  - Mode encodings `MODE_UP`, `MODE_DOWN`, `MODE_PINGPONG`, `MODE_HOLD`.
  - FSM state constants `ST_UP`, `ST_DOWN`.
  - Default `WIDTH` = 6.
- One sub-module `rise_detect` (register plus AND-NOT, output `rise`), so the same edge detector is reused by other scope stages.
- Counter, FSM and output registers live in `counter6_step`. Target 150–250 lines.

## Test plan
- Reset; `mode`=00, `limit`=63, `en`=1, `tick` period 7 → `count` reaches 63 at step 63; step 64 gives `count`=0 and a single-clock `tc`; `step` pulses 7 clocks apart.
- `mode`=00, `limit`=5 → 0,1,2,3,4,5,0 with `tc` at the 5→0 transition; `load_val`=50 with `load`=1 → next step gives 0 with `tc`.
- `mode`=10, `limit`=3 → 0,1,2,3,2,1,0,1; `dir` rises at 3→2 and falls at 0→1; `tc` pulses at both turn-arounds.
- `mode`=01, `limit`=4, `load`=1 with `load_val`=2 on the same cycle as `rise` → `count`=2, no step; following steps give 1,0,4 with `tc` at 0→4.
- `en`=0 for two tick periods, then `mode`=11 for two periods → `count` unchanged and no `step`/`tc`; resuming `mode`=00 continues from the held value.
- `rst_n` pulsed low for 3 ns mid-count at `count`=17 → `count`, `dir`, `tc` and `step` are 0 immediately; counting restarts from 0 on the first rise after release.

Source files
------------

// File: rtl/counter6_pkg.sv
// Shared encodings and defaults for the scope counter stage.
package counter6_pkg;

  localparam int WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_t;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } state_t;

endpackage

// File: rtl/counter6_if.sv
// Control and status bundle between the scope sequencer and counter6_step.
interface counter6_if
  import counter6_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             tick;
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             step;

  modport master (
    output tick, en, mode, limit, load, load_val,
    input  count, dir, tc, step
  );

  modport slave (
    input  tick, en, mode, limit, load, load_val,
    output count, dir, tc, step
  );
endinterface

// File: rtl/counter6_step_rise_detect.sv
// Rising-edge detector for a level that is already synchronous to clock.
module rise_detect (
  input  logic clock,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);
  logic sig_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/counter6_step.sv
// Programmable 6-bit counter stepped by rising edges of the divided tick.
// state   | meaning
// ST_UP   | counting up (dir = 0)
// ST_DOWN | counting down (dir = 1)
module counter6_step
  import counter6_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
)(
  input logic        clock,
  input logic        rst_n,
  counter6_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             rise;
  logic             accept;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             step_q, step_d;

  rise_detect u_rise (
    .clock  (clock),
    .rst_n  (rst_n),
    .sig_i  (bus.tick),
    .rise_o (rise)
  );

  assign accept = rise & bus.en & ~bus.load & (bus.mode != MODE_HOLD);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;
    step_d  = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (accept) begin
      step_d = 1'b1;
      case (bus.mode)
        MODE_UP: begin
          state_d = ST_UP;
          if (count_q < bus.limit) begin
            count_d = count_q + ONE;
          end else begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end
        MODE_DOWN: begin
          state_d = ST_DOWN;
          if (count_q == '0) begin
            count_d = bus.limit;
            tc_d    = 1'b1;
          end else if (count_q > bus.limit) begin
            count_d = bus.limit;
          end else begin
            count_d = count_q - ONE;
          end
        end
        MODE_PINGPONG: begin
          // A zero limit would make limit-1 underflow; pin at 0 and flag every step.
          if (bus.limit == '0) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else if (state_q == ST_UP) begin
            if (count_q < bus.limit) begin
              count_d = count_q + ONE;
            end else begin
              count_d = bus.limit - ONE;
              state_d = ST_DOWN;
              tc_d    = 1'b1;
            end
          end else begin
            if (count_q > bus.limit) begin
              count_d = bus.limit;
            end else if (count_q == '0) begin
              count_d = ONE;
              state_d = ST_UP;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      state_q <= ST_UP;
      tc_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      tc_q    <= tc_d;
      step_q  <= step_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = (state_q == ST_DOWN);
  assign bus.tc    = tc_q;
  assign bus.step  = step_q;
endmodule

// File: tb/tb_counter6_step.sv
// Self-checking bench for counter6_step: directed vector table, corner sequences, random run vs model.
module tb_counter6_step;
  import counter6_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  counter6_if bus ();

  counter6_step dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  // Behavioural reference: next outputs from the rules, using plain integers.
  typedef struct packed {
    int cnt;
    bit dir;
    bit tc;
    bit step;
    bit tprev;
  } mstate_t;

  function automatic mstate_t model_next(mstate_t s, bit tk, bit en, int mode, int lim,
                                         bit ld, int ldv);
    mstate_t n = s;
    n.tprev = tk;
    n.tc    = 0;
    n.step  = 0;
    if (ld) n.cnt = ldv;
    else if (tk && !s.tprev && en && mode != 3) begin
      n.step = 1;
      if (mode == 0) begin
        n.dir = 0;
        if (s.cnt < lim) n.cnt = s.cnt + 1;
        else begin n.cnt = 0; n.tc = 1; end
      end else if (mode == 1) begin
        n.dir = 1;
        if (s.cnt == 0) begin n.cnt = lim; n.tc = 1; end
        else if (s.cnt > lim) n.cnt = lim;
        else n.cnt = s.cnt - 1;
      end else if (lim == 0) begin
        n.cnt = 0; n.tc = 1;
      end else if (!s.dir) begin
        if (s.cnt < lim) n.cnt = s.cnt + 1;
        else begin n.cnt = lim - 1; n.dir = 1; n.tc = 1; end
      end else begin
        if (s.cnt > lim) n.cnt = lim;
        else if (s.cnt == 0) begin n.cnt = 1; n.dir = 0; n.tc = 1; end
        else n.cnt = s.cnt - 1;
      end
    end
    return n;
  endfunction

  mstate_t m = '0;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_next(m, bus.tick, bus.en, int'(bus.mode), int'(bus.limit),
                         bus.load, int'(bus.load_val));
  end

  always @(negedge clock) begin
    if (rst_n) begin
      chk("mdl_count", cyc, int'(bus.count), m.cnt);
      chk("mdl_dir",   cyc, int'(bus.dir),   int'(m.dir));
      chk("mdl_tc",    cyc, int'(bus.tc),    int'(m.tc));
      chk("mdl_step",  cyc, int'(bus.step),  int'(m.step));
    end
  end

  typedef struct {
    bit ld; int ldv; int mode; int lim; bit en; bit tk;
    int cnt; bit dir; bit tc; bit st;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit ld, input int ldv, input int mode, input int lim, input bit en,
                     input bit tk, input int cnt, input bit dir, input bit tc, input bit st);
    vec_t v;
    v.ld = ld; v.ldv = ldv; v.mode = mode; v.lim = lim; v.en = en; v.tk = tk;
    v.cnt = cnt; v.dir = dir; v.tc = tc; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
  endtask

  int last_cyc;
  int nsteps;

  initial begin
    bus.tick = 0; bus.en = 1; bus.mode = MODE_UP; bus.limit = 6'd63;
    bus.load = 0; bus.load_val = '0;

    // up-wrap, limit 5, then out-of-range load wraps to 0
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 5, 1, 1, k, 0, 0, 1);
    add(0, 0, 0, 5, 1, 1, 0, 0, 1, 1);
    add(1, 50, 0, 5, 1, 0, 50, 0, 0, 0);
    add(0, 0, 0, 5, 1, 1, 0, 0, 1, 1);
    // ping-pong, limit 3
    add(0, 0, 2, 3, 1, 1, 1, 0, 0, 1);
    add(0, 0, 2, 3, 1, 1, 2, 0, 0, 1);
    add(0, 0, 2, 3, 1, 1, 3, 0, 0, 1);
    add(0, 0, 2, 3, 1, 1, 2, 1, 1, 1);
    add(0, 0, 2, 3, 1, 1, 1, 1, 0, 1);
    add(0, 0, 2, 3, 1, 1, 0, 1, 0, 1);
    add(0, 0, 2, 3, 1, 1, 1, 0, 1, 1);
    // load coincident with rise, then down-wrap
    add(1, 2, 1, 4, 1, 1, 2, 0, 0, 0);
    add(0, 0, 1, 4, 1, 1, 1, 1, 0, 1);
    add(0, 0, 1, 4, 1, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4, 1, 1, 4, 1, 1, 1);
    // limit 0
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    // ping-pong, limit 1
    add(0, 0, 2, 1, 1, 1, 1, 0, 0, 1);
    add(0, 0, 2, 1, 1, 1, 0, 1, 1, 1);
    add(0, 0, 2, 1, 1, 1, 1, 0, 1, 1);
    // hold, disable, resume
    add(0, 0, 3, 5, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 5, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 5, 1, 1, 2, 0, 0, 1);
    // down-wrap from above limit clamps without tc
    add(1, 40, 1, 4, 1, 0, 40, 0, 0, 0);
    add(0, 0, 1, 4, 1, 1, 4, 1, 0, 1);

    repeat (2) @(negedge clock);
    chk("rst_count", 0, int'(bus.count), 0);
    chk("rst_dir",   0, int'(bus.dir),   0);
    chk("rst_tc",    0, int'(bus.tc),    0);
    chk("rst_step",  0, int'(bus.step),  0);
    rst_n = 1'b1;
    @(negedge clock);

    // full-range up-wrap at the upstream period of 7
    last_cyc = 0;
    for (int k = 1; k <= 64; k++) begin
      bus.tick = 1;
      @(negedge clock);
      chk("p7_step", k, int'(bus.step), 1);
      chk("p7_count", k, int'(bus.count), k % 64);
      if (k > 1) chk("p7_spacing", k, cyc - last_cyc, 7);
      last_cyc = cyc;
      if (k == 64) chk("p7_tc", k, int'(bus.tc), 1);
      bus.tick = 0;
      @(negedge clock);
      if (k == 64) chk("p7_tc_width", k, int'(bus.tc), 0);
      repeat (5) @(negedge clock);
    end

    // async reset mid-count at 17
    for (int k = 1; k <= 16; k++) begin
      bus.tick = 1; @(negedge clock);
      bus.tick = 0; @(negedge clock);
    end
    bus.tick = 1;
    @(negedge clock);
    chk("pre_rst_count", 17, int'(bus.count), 17);
    #1 rst_n = 1'b0; bus.tick = 0;
    #1;
    chk("arst_count", 0, int'(bus.count), 0);
    chk("arst_dir",   0, int'(bus.dir),   0);
    chk("arst_tc",    0, int'(bus.tc),    0);
    chk("arst_step",  0, int'(bus.step),  0);
    #2 rst_n = 1'b1;
    @(negedge clock);
    chk("post_rst_count", 0, int'(bus.count), 0);
    bus.tick = 1;
    @(negedge clock);
    chk("post_rst_step1", 0, int'(bus.count), 1);
    bus.tick = 0;
    @(negedge clock);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.load = tbl[i].ld; bus.load_val = 6'(tbl[i].ldv);
      bus.mode = mode_t'(2'(tbl[i].mode)); bus.limit = 6'(tbl[i].lim);
      bus.en = tbl[i].en; bus.tick = tbl[i].tk;
      @(negedge clock);
      chk("tbl_count", i, int'(bus.count), tbl[i].cnt);
      chk("tbl_dir",   i, int'(bus.dir),   int'(tbl[i].dir));
      chk("tbl_tc",    i, int'(bus.tc),    int'(tbl[i].tc));
      chk("tbl_step",  i, int'(bus.step),  int'(tbl[i].st));
      bus.tick = 0; bus.load = 0;
      @(negedge clock);
    end

    // tick held high yields a single step
    bus.mode = MODE_UP; bus.limit = 6'd63; bus.en = 1; bus.tick = 1;
    nsteps = 0;
    repeat (6) begin
      @(negedge clock);
      nsteps += int'(bus.step);
    end
    chk("held_tick_steps", 0, nsteps, 1);
    bus.tick = 0;
    @(negedge clock);

    // random run against the reference model
    for (int i = 0; i < 3000; i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.en   = ($urandom_range(0, 7) != 0);
      bus.load = ($urandom_range(0, 19) == 0);
      bus.load_val = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) bus.mode = mode_t'(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0)
        bus.limit = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3))
                                               : 6'($urandom_range(0, 63));
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
